// File: rtl/quad_encoder_tx.sv
// Quadrature encoder transmitter: turns step commands into a Gray-coded QA/QB
// waveform, holding each state for DWELL_CYC clocks. It is the source side for decoder_up_down.
module quad_encoder_tx #(
    parameter int DWELL_CYC = 4,
    parameter int STEP_W    = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_DIR,
    input  logic [STEP_W-1:0] CMD_STEPS,
    output logic              Enc_QA,
    output logic              Enc_QB,
    output logic              STEP_PULSE,
    output logic              CMD_DONE,
    output logic              BUSY
);

    localparam int DW_W = $clog2(DWELL_CYC + 1);

    localparam logic [0:0]        ST_IDLE    = 1'b0;
    localparam logic [0:0]        ST_RUN     = 1'b1;
    localparam logic [DW_W-1:0]   DW_RELOAD  = DW_W'(DWELL_CYC - 1);
    localparam logic [DW_W-1:0]   DW_ZERO    = {DW_W{1'b0}};
    localparam logic [DW_W-1:0]   DW_ONE     = DW_W'(1);
    localparam logic [STEP_W-1:0] STEP_ZERO  = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);

    // The phase index walks 0..3 as (QA,QB) = 00,10,11,01. Up increments and down decrements it,
    // so wrap-around keeps the Gray property in both directions.
    function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic dir);
        logic [1:0] res;
        if (dir) begin
            res = phase + 2'd1;
        end else begin
            res = phase - 2'd1;
        end
        return res;
    endfunction

    function automatic logic phase_qa(input logic [1:0] phase);
        return phase[1] ^ phase[0];
    endfunction

    function automatic logic phase_qb(input logic [1:0] phase);
        return phase[1];
    endfunction

    logic [0:0]        state_q, state_d;
    logic              ready_q, ready_d;
    logic              dir_q, dir_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [1:0]        phase_q, phase_d;
    logic              qa_q, qa_d;
    logic              qb_q, qb_d;
    logic              pulse_q, pulse_d;
    logic              done_q, done_d;

    // Next-state logic for the command FSM, dwell timer and phase.
    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        dwell_d = dwell_q;
        phase_d = phase_q;
        pulse_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (CMD_VALID && ready_q) begin
                    dir_d   = CMD_DIR;
                    rem_d   = CMD_STEPS;
                    // Zero dwell makes the first transition land on the very next edge.
                    dwell_d = DW_ZERO;
                    if (CMD_STEPS != STEP_ZERO) begin
                        state_d = ST_RUN;
                        ready_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (dwell_q == DW_ZERO) begin
                    if (rem_q == STEP_ZERO) begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        phase_d = next_phase(phase_q, dir_q);
                        pulse_d = 1'b1;
                        rem_d   = rem_q - STEP_ONE;
                        dwell_d = DW_RELOAD;
                    end
                end else begin
                    dwell_d = dwell_q - DW_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b0;
            end
        endcase

        qa_d = phase_qa(phase_d);
        qb_d = phase_qb(phase_d);
    end

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            dir_q   <= 1'b0;
            rem_q   <= STEP_ZERO;
            dwell_q <= DW_ZERO;
            phase_q <= 2'b00;
            qa_q    <= 1'b0;
            qb_q    <= 1'b0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            dwell_q <= dwell_d;
            phase_q <= phase_d;
            qa_q    <= qa_d;
            qb_q    <= qb_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
        end
    end

    assign CMD_READY  = ready_q;
    assign BUSY       = (state_q == ST_RUN);
    assign Enc_QA     = qa_q;
    assign Enc_QB     = qb_q;
    assign STEP_PULSE = pulse_q;
    assign CMD_DONE   = done_q;

endmodule

// File: tb/tb_quad_encoder_tx.sv
// Scoreboard bench for quad_encoder_tx: stimulus pushes expected transitions and
// completions with their edge numbers; a negedge monitor pops and compares them.
module tb_quad_encoder_tx;

    localparam int D = 4;

    logic       CLK;
    logic       RST;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic       CMD_DIR;
    logic [3:0] CMD_STEPS;
    logic       Enc_QA;
    logic       Enc_QB;
    logic       STEP_PULSE;
    logic       CMD_DONE;
    logic       BUSY;

    quad_encoder_tx #(.DWELL_CYC(D), .STEP_W(4)) dut (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_DIR(CMD_DIR), .CMD_STEPS(CMD_STEPS), .Enc_QA(Enc_QA), .Enc_QB(Enc_QB),
        .STEP_PULSE(STEP_PULSE), .CMD_DONE(CMD_DONE), .BUSY(BUSY)
    );

    typedef struct {
        int         cyc;
        logic [1:0] q;
    } step_t;

    step_t      step_q[$];
    int         done_q[$];
    logic [1:0] seq[4];
    int         mphase;
    int         vectors;
    int         miscompares;
    int         edge_cnt;
    logic       rst_seen;
    logic [1:0] prev_q;
    int         up_cnt;
    int         dn_cnt;
    int         last_k;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        edge_cnt <= edge_cnt + 1;
        rst_seen <= RST;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic int q_idx(input logic [1:0] q);
        case (q)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Expected transitions land on edges k+1+i*D, completion on k+1+N*D.
    task automatic push_cmd(input logic d, input int n, input int k);
        step_t s;
        for (int i = 0; i < n; i++) begin
            mphase = d ? (mphase + 1) % 4 : (mphase + 3) % 4;
            s.cyc  = k + 1 + i * D;
            s.q    = seq[mphase];
            step_q.push_back(s);
        end
        if (n > 0) done_q.push_back(k + 1 + n * D);
    endtask

    task automatic send(input logic d, input int n);
        int b;
        b = 0;
        @(negedge CLK);
        while (!CMD_READY && b < 500) begin
            @(negedge CLK);
            b++;
        end
        if (!CMD_READY) check("send_ready_timeout", int'(CMD_READY), 1);
        CMD_VALID = 1'b1;
        CMD_DIR   = d;
        CMD_STEPS = 4'(n);
        last_k    = edge_cnt + 1;
        push_cmd(d, n, last_k);
        @(negedge CLK);
        CMD_VALID = 1'b0;
        CMD_DIR   = ~d;
        CMD_STEPS = 4'hF;
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while (!(CMD_READY && step_q.size() == 0 && done_q.size() == 0) && b < 2000) begin
            @(negedge CLK);
            b++;
        end
        check("idle_reached", int'(b < 2000), 1);
    endtask

    // Monitor: Gray/strobe alignment, decoder-style up/down counting, scoreboard pops.
    always @(negedge CLK) begin
        step_t e;
        if (rst_seen) begin
            prev_q = {Enc_QA, Enc_QB};
        end else begin
            if ({Enc_QA, Enc_QB} != prev_q) begin
                check("gray_one_bit", $countones({Enc_QA, Enc_QB} ^ prev_q), 1);
                check("change_has_pulse", int'(STEP_PULSE), 1);
                if (q_idx({Enc_QA, Enc_QB}) == (q_idx(prev_q) + 1) % 4) up_cnt++;
                else dn_cnt++;
                prev_q = {Enc_QA, Enc_QB};
            end
            if (STEP_PULSE) begin
                if (step_q.size() == 0) begin
                    check("unexpected_step", 1, 0);
                end else begin
                    e = step_q.pop_front();
                    check("step_edge", edge_cnt, e.cyc);
                    check("step_qaqb", int'({Enc_QA, Enc_QB}), int'(e.q));
                end
            end
            if (CMD_DONE) begin
                if (done_q.size() == 0) check("unexpected_done", 1, 0);
                else check("done_edge", edge_cnt, done_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    logic tbl_dir[5];
    int   tbl_st[5];

    initial begin
        int hs;
        int c;
        seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
        tbl_dir[0] = 1'b1; tbl_dir[1] = 1'b0; tbl_dir[2] = 1'b1; tbl_dir[3] = 1'b1; tbl_dir[4] = 1'b0;
        tbl_st[0] = 2;     tbl_st[1] = 3;     tbl_st[2] = 0;     tbl_st[3] = 1;     tbl_st[4] = 2;
        mphase = 0; vectors = 0; miscompares = 0; edge_cnt = 0;
        up_cnt = 0; dn_cnt = 0; prev_q = 2'b00; last_k = 0;
        RST = 1'b1; CMD_VALID = 1'b0; CMD_DIR = 1'b0; CMD_STEPS = 4'd0;

        // Reset state.
        repeat (3) @(negedge CLK);
        check("rst_qaqb", int'({Enc_QA, Enc_QB}), 0);
        check("rst_ready", int'(CMD_READY), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_pulse", int'(STEP_PULSE), 0);
        check("rst_done", int'(CMD_DONE), 0);
        RST = 1'b0;
        @(negedge CLK);
        check("ready_after_release", int'(CMD_READY), 1);
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            check("idle_pulse", int'(STEP_PULSE), 0);
            check("idle_done", int'(CMD_DONE), 0);
        end
        check("idle_qaqb", int'({Enc_QA, Enc_QB}), 0);

        // Up 4 steps: 10,11,01,00 then done at k+17.
        send(1'b1, 4);
        wait_idle();
        check("after_up4", int'({Enc_QA, Enc_QB}), 0);

        // Down 3 from 00: 01,11,10; then back-to-back up 1: 11.
        send(1'b0, 3);
        send(1'b1, 1);
        wait_idle();
        check("after_down3_up1", int'({Enc_QA, Enc_QB}), 3);

        // Zero-step handshake: nothing moves, ready stays high.
        send(1'b1, 0);
        check("zero_ready", int'(CMD_READY), 1);
        check("zero_busy", int'(BUSY), 0);
        repeat (10) @(negedge CLK);
        check("zero_ready_later", int'(CMD_READY), 1);
        check("zero_qaqb", int'({Enc_QA, Enc_QB}), 3);

        // Valid held high, payload changing every cycle.
        hs = 0;
        c  = 0;
        while (hs < 4 && c < 400) begin
            @(negedge CLK);
            CMD_VALID = 1'b1;
            CMD_DIR   = tbl_dir[c % 5];
            CMD_STEPS = 4'(tbl_st[c % 5]);
            if (CMD_READY) begin
                push_cmd(CMD_DIR, tbl_st[c % 5], edge_cnt + 1);
                hs++;
            end
            c++;
        end
        @(negedge CLK);
        CMD_VALID = 1'b0;
        check("stream_handshakes", hs, 4);
        wait_idle();

        // Reset one cycle after the 2nd transition of an 8-step command.
        send(1'b1, 8);
        while (edge_cnt < last_k + 1 + D) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("abort_qaqb", int'({Enc_QA, Enc_QB}), 0);
        check("abort_pulse", int'(STEP_PULSE), 0);
        check("abort_ready", int'(CMD_READY), 0);
        check("abort_busy", int'(BUSY), 0);
        check("abort_steps_pending", step_q.size(), 6);
        check("abort_done_pending", done_q.size(), 1);
        step_q.delete();
        done_q.delete();
        mphase = 0;
        RST = 1'b0;
        @(negedge CLK);
        check("abort_ready_release", int'(CMD_READY), 1);
        repeat (40) @(negedge CLK);
        check("abort_qaqb_held", int'({Enc_QA, Enc_QB}), 0);

        // Decoder-style loopback count.
        up_cnt = 0;
        dn_cnt = 0;
        send(1'b1, 8);
        wait_idle();
        check("loop_up", up_cnt, 8);
        check("loop_down", dn_cnt, 0);

        repeat (5) @(negedge CLK);
        check("final_steps_left", step_q.size(), 0);
        check("final_done_left", done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/quad_encoder_tx.md
QUAD_ENCODER_TX -- requirements
Module: quad_encoder_tx

Interface
REQ-001 Parameter DWELL_CYC, default 4: CLK cycles each quadrature state is held; legal range 1..1023.
REQ-002 Parameter STEP_W, default 4: width of the step-count field.
REQ-003 CLK  input  1  single system clock; all logic on its rising edge.
REQ-004 RST  input  1  reset; synchronous and active-high.
REQ-005 CMD_VALID  input  1  step command offered.
REQ-006 CMD_READY  output  1  block can accept a command.
REQ-007 CMD_DIR  input  1  direction: 1 = up, 0 = down.
REQ-008 CMD_STEPS  input  STEP_W  number of quadrature transitions to emit.
REQ-009 Enc_QA  output  1  quadrature channel A, registered.
REQ-010 Enc_QB  output  1  quadrature channel B, registered.
REQ-011 STEP_PULSE  output  1  one-cycle strobe on each emitted transition.
REQ-012 CMD_DONE  output  1  one-cycle strobe when a non-zero command completes.
REQ-013 BUSY  output  1  high while a command is executing.

Function
REQ-014 The block SHALL act as the transmitter for decoder_up_down: it generates Enc_QA/Enc_QB waveforms for a CPU player, test stimulus, or loopback.
REQ-015 The up sequence SHALL be (QA,QB) 00->10->11->01->00, with QA leading; the down sequence SHALL be its exact reverse.
REQ-016 Exactly one of Enc_QA/Enc_QB SHALL change per transition (Gray), with no glitches; both are driven directly from flops.
REQ-017 A 2-bit phase register SHALL persist across commands; a new command continues from the current phase, with no return to 00.
REQ-018 FSM states SHALL be IDLE and RUN; CMD_READY = 1 only in IDLE; BUSY = (state == RUN).
REQ-019 A handshake SHALL occur on a rising edge with CMD_VALID && CMD_READY; CMD_DIR and CMD_STEPS SHALL be captured on that edge only.
REQ-020 CMD_VALID SHALL be ignored while CMD_READY = 0; payload changes during RUN SHALL have no effect.
REQ-021 CMD_STEPS = 0 SHALL be accepted with no transitions: state stays IDLE, CMD_READY stays 1, and neither STEP_PULSE nor CMD_DONE is asserted.
REQ-022 CMD_STEPS = N > 0, accepted at edge k, SHALL cause transitions at edges k+1+i*DWELL_CYC for i = 0..N-1.
REQ-023 The first transition SHALL have one-cycle latency from acceptance.
REQ-024 STEP_PULSE SHALL be high for exactly the cycle following each transition edge, aligned with the new Enc_QA/Enc_QB values.
REQ-025 After the last transition is held DWELL_CYC cycles, the FSM SHALL enter IDLE at edge k+1+N*DWELL_CYC.
REQ-026 At that same edge, CMD_READY SHALL rise and CMD_DONE SHALL pulse for one cycle.
REQ-027 A back-to-back command accepted on the CMD_READY-rising cycle SHALL start transitions on the next edge, giving no dead time beyond DWELL_CYC.
REQ-028 When DWELL_CYC = 1, a transition SHALL occur every cycle for N consecutive cycles.
REQ-029 The remaining-step counter SHALL be STEP_W bits and count down to 0 with no wrap.
REQ-030 The dwell counter SHALL be ceil(log2(DWELL_CYC+1)) bits and reload on each transition.
REQ-031 The maximum command SHALL be 2^STEP_W-1 steps; larger moves require multiple commands.

Reset
REQ-032 While RST = 1 at an edge, the block SHALL set Enc_QA = 0, Enc_QB = 0, phase = 00, state = IDLE, STEP_PULSE = 0, CMD_DONE = 0, BUSY = 0 and CMD_READY = 0.
REQ-033 CMD_READY SHALL go to 1 at the first rising edge with RST = 0.
REQ-034 RST asserted mid-command SHALL abort the command: remaining steps are discarded, no CMD_DONE is issued, and outputs reach 00 at that edge.

Verification
REQ-035 Release reset, no commands: Enc_QA/Enc_QB = 00, CMD_READY = 1 after one edge, and STEP_PULSE/CMD_DONE stay 0 for 100 cycles.
REQ-036 DIR=1, STEPS=4, DWELL_CYC=4, accepted at edge 0: (QA,QB) = 10, 11, 01, 00 at edges 1, 5, 9, 13; 4 STEP_PULSEs; CMD_READY and CMD_DONE at edge 17.
REQ-037 From phase 00, DIR=0, STEPS=3: sequence 01, 11, 10; a following DIR=1, STEPS=1 yields 11.
REQ-038 STEPS=0 handshake: no output change, CMD_READY never drops, and no CMD_DONE.
REQ-039 CMD_VALID held high with a changing payload during RUN: only the payload present at each CMD_READY handshake executes, exactly once per handshake.
REQ-040 DIR=1, STEPS=8, RST pulsed one cycle after the 2nd transition: outputs 00 at the reset edge, no further STEP_PULSE, CMD_READY = 1 one edge after release, and no CMD_DONE.
REQ-041 Loopback into decoder_up_down, DIR=1, STEPS=8: the decoder's up strobes total the expected count and down stays 0.
